bitser_ctrl_p: RTL and testbench

- Parametrised control FSM for the bit-serial CPU datapath. Sequences one instruction through operand fetch, serial execute and register writeback, LSB first, one bit per clock.
- Replaces the button/inst_done front end with a start/ready handshake and an internal bit counter.
- Adds width/address parametrisation, immediate bit generation, R0 write suppression, illegal-opcode error and abort.

---
 rtl/bitser_ctrl_p.sv | 192 +++++++++++++++++++
 tb/tb_bitser_ctrl_p.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitser_ctrl_p.sv
// Control FSM for the bit-serial CPU datapath: one instruction is sequenced through
// operand fetch, serial execute and writeback, LSB first, one bit per clock.
module bitser_ctrl_p #(
  parameter int DATA_W   = 8,
  parameter int RADDR_W  = 3,
  parameter int INSTR_W  = 16,
  parameter int IMM_SEXT = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [INSTR_W-1:0]        instr,
  input  logic                      abort,
  output logic                      ready,
  output logic                      done,
  output logic                      err,
  output logic [RADDR_W-1:0]        reg_addr,
  output logic                      reg_rd_en,
  output logic                      reg_wr_en,
  output logic                      opa_shift_en,
  output logic                      opb_shift_en,
  output logic                      opb_sel_imm,
  output logic                      imm_bit,
  output logic [1:0]                alu_op,
  output logic                      sub_mode,
  output logic                      carry_ld,
  output logic                      carry_en,
  output logic                      acc_shift_en,
  output logic [$clog2(DATA_W)-1:0] bit_idx
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int IMM_W = INSTR_W - 4 - 2*RADDR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W-1);

  typedef struct packed {
    logic [IMM_W-1:0]   imm;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rd;
    logic [3:0]         opc;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_EXE, S_WB, S_DONE
  } state_t;

  state_t             st, st_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  instr_t             ir;
  logic               accept, last;
  logic               itype, illegal, is_mov, is_sub;
  logic [2:0]         op3;
  logic [1:0]         dec_alu;
  logic [RADDR_W-1:0] rs2;
  logic [DATA_W-1:0]  imm_ext;

  assign accept  = (st == S_IDLE) && start;
  assign last    = (cnt == CNT_LAST);
  assign op3     = ir.opc[2:0];
  assign itype   = ir.opc[3];
  assign illegal = op3[2] & op3[1];
  assign is_mov  = (op3 == 3'b101);
  assign is_sub  = (op3 == 3'b001);
  assign rs2     = ir.imm[RADDR_W-1:0];
  assign bit_idx = cnt;

  // Immediate widened to the datapath so the counter can index it directly.
  for (genvar i = 0; i < DATA_W; i++) begin : g_imm
    if (i < IMM_W) begin : g_fld
      assign imm_ext[i] = ir.imm[i];
    end else if (IMM_SEXT != 0) begin : g_sx
      assign imm_ext[i] = ir.imm[IMM_W-1];
    end else begin : g_zx
      assign imm_ext[i] = 1'b0;
    end
  end

  always_comb begin
    dec_alu = 2'b00;
    case (op3)
      3'b010:  dec_alu = 2'b10;
      3'b011:  dec_alu = 2'b11;
      3'b100:  dec_alu = 2'b01;
      3'b101:  dec_alu = 2'b11;
      default: dec_alu = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= S_IDLE;
      cnt <= '0;
      ir  <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      if (accept) ir <= instr_t'(instr);
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    case (st)
      S_IDLE: begin
        if (start) begin
          // Illegal opcodes are decoded from the live word since ir is not yet loaded.
          st_nx  = (instr[2] & instr[1]) ? S_DONE : S_RDA;
          cnt_nx = '0;
        end
      end
      S_RDA, S_RDB, S_EXE, S_WB: begin
        cnt_nx = last ? '0 : cnt + 1'b1;
        if (last) begin
          case (st)
            S_RDA:   st_nx = S_RDB;
            S_RDB:   st_nx = S_EXE;
            S_EXE:   st_nx = S_WB;
            default: st_nx = S_DONE;
          endcase
        end
      end
      S_DONE:  st_nx = S_IDLE;
      default: begin
        st_nx  = S_IDLE;
        cnt_nx = '0;
      end
    endcase
    if (abort && st != S_IDLE) begin
      st_nx  = S_IDLE;
      cnt_nx = '0;
    end
  end

  always_comb begin
    ready        = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    reg_addr     = '0;
    reg_rd_en    = 1'b0;
    reg_wr_en    = 1'b0;
    opa_shift_en = 1'b0;
    opb_shift_en = 1'b0;
    opb_sel_imm  = 1'b0;
    imm_bit      = 1'b0;
    alu_op       = 2'b00;
    sub_mode     = 1'b0;
    carry_ld     = 1'b0;
    carry_en     = 1'b0;
    acc_shift_en = 1'b0;
    case (st)
      S_IDLE: ready = 1'b1;
      S_RDA: begin
        reg_addr     = ir.rs1;
        reg_rd_en    = 1'b1;
        opa_shift_en = 1'b1;
      end
      S_RDB: begin
        opb_shift_en = 1'b1;
        if (is_mov) begin
          opb_sel_imm = 1'b1;
        end else if (itype) begin
          opb_sel_imm = 1'b1;
          imm_bit     = imm_ext[cnt];
        end else begin
          reg_addr  = rs2;
          reg_rd_en = 1'b1;
        end
      end
      S_EXE: begin
        alu_op       = dec_alu;
        sub_mode     = is_sub;
        carry_en     = 1'b1;
        carry_ld     = (cnt == '0);
        acc_shift_en = 1'b1;
        opa_shift_en = 1'b1;
        opb_shift_en = 1'b1;
      end
      S_WB: begin
        acc_shift_en = 1'b1;
        reg_addr     = ir.rd;
        reg_wr_en    = |ir.rd;
      end
      S_DONE: begin
        done = 1'b1;
        err  = illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bitser_ctrl_p.sv
// Directed bench for bitser_ctrl_p: cycle-by-cycle control timeline for legal
// instructions, illegal opcode, abort, back-to-back start, reset mid-WB, DATA_W=16.
module tb_bitser_ctrl_p;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, start16 = 1'b0;
  logic [15:0] instr = '0;

  logic       ready, done, err, reg_rd_en, reg_wr_en, opa_shift_en, opb_shift_en;
  logic       opb_sel_imm, imm_bit, sub_mode, carry_ld, carry_en, acc_shift_en;
  logic [2:0] reg_addr, bit_idx;
  logic [1:0] alu_op;

  logic       ready16, done16, err16, rd16, wr16, opa16, opb16, sel16, imm16;
  logic       sub16, cld16, cen16, acc16;
  logic [2:0] addr16;
  logic [1:0] alu16;
  logic [3:0] idx16;

  logic [11:0] outv;
  assign outv = {reg_rd_en, reg_wr_en, opa_shift_en, opb_shift_en, opb_sel_imm, imm_bit,
                 sub_mode, carry_ld, carry_en, acc_shift_en, done, err};

  int n_cmp = 0, n_bad = 0;
  logic [2:0] cur_rd, cur_rs1, cur_rs2;
  logic       cur_rtype, cur_sub;
  logic [1:0] cur_aop;
  logic [7:0] cur_immv;

  bitser_ctrl_p #(.DATA_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .instr(instr), .abort(abort),
    .ready(ready), .done(done), .err(err), .reg_addr(reg_addr), .reg_rd_en(reg_rd_en),
    .reg_wr_en(reg_wr_en), .opa_shift_en(opa_shift_en), .opb_shift_en(opb_shift_en),
    .opb_sel_imm(opb_sel_imm), .imm_bit(imm_bit), .alu_op(alu_op), .sub_mode(sub_mode),
    .carry_ld(carry_ld), .carry_en(carry_en), .acc_shift_en(acc_shift_en), .bit_idx(bit_idx)
  );

  bitser_ctrl_p #(.DATA_W(16)) dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .instr(instr), .abort(1'b0),
    .ready(ready16), .done(done16), .err(err16), .reg_addr(addr16), .reg_rd_en(rd16),
    .reg_wr_en(wr16), .opa_shift_en(opa16), .opb_shift_en(opb16),
    .opb_sel_imm(sel16), .imm_bit(imm16), .alu_op(alu16), .sub_mode(sub16),
    .carry_ld(cld16), .carry_en(cen16), .acc_shift_en(acc16), .bit_idx(idx16)
  );

  always #5 clk = ~clk;

  task automatic ck(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [3:0] opc, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [5:0] imm, input logic rtype, input logic [1:0] aop,
                       input logic sub, input logic [7:0] immv);
    instr     = {imm, rs1, rd, opc};
    cur_rd    = rd;
    cur_rs1   = rs1;
    cur_rs2   = imm[2:0];
    cur_rtype = rtype;
    cur_aop   = aop;
    cur_sub   = sub;
    cur_immv  = immv;
  endtask

  // Cycle c is counted from the accept cycle (c=0).
  task automatic chk_cycle(input int c);
    bit a, b, e, w, ser;
    logic [2:0] ea;
    a   = (c >= 1  && c <= 8);
    b   = (c >= 9  && c <= 16);
    e   = (c >= 17 && c <= 24);
    w   = (c >= 25 && c <= 32);
    ser = a | b | e | w;
    ea  = a ? cur_rs1 : (b && cur_rtype) ? cur_rs2 : w ? cur_rd : 3'd0;
    ck("ready",    c, ready,        (c == 0 || c == 34));
    ck("done",     c, done,         (c == 33));
    ck("err",      c, err,          0);
    ck("reg_addr", c, reg_addr,     ea);
    ck("rd_en",    c, reg_rd_en,    a || (b && cur_rtype));
    ck("wr_en",    c, reg_wr_en,    w && (cur_rd != 0));
    ck("opa",      c, opa_shift_en, a || e);
    ck("opb",      c, opb_shift_en, b || e);
    ck("sel_imm",  c, opb_sel_imm,  b && !cur_rtype);
    ck("imm_bit",  c, imm_bit,      (b && !cur_rtype) ? cur_immv[c-9] : 1'b0);
    ck("alu_op",   c, alu_op,       e ? cur_aop : 2'b00);
    ck("sub_mode", c, sub_mode,     e && cur_sub);
    ck("carry_ld", c, carry_ld,     (c == 17));
    ck("carry_en", c, carry_en,     e);
    ck("acc",      c, acc_shift_en, e || w);
    ck("bit_idx",  c, bit_idx,      ser ? (c - 1) % 8 : 0);
  endtask

  task automatic run(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      chk_cycle(c);
      if (c != to) tick;
    end
  endtask

  task automatic issue(input bit hold);
    start = 1'b1;
    chk_cycle(0);
    tick;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int n;
    #3;
    ck("rst_ready", 0, ready, 1);
    ck("rst_outs",  0, outv, 0);
    ck("rst_addr",  0, reg_addr, 0);
    ck("rst_idx",   0, bit_idx, 0);
    tick; tick;
    rstn = 1'b1;
    tick;

    // ADD rd=2 rs1=3 rs2=4
    setup(4'b0000, 3'd2, 3'd3, 6'b000100, 1'b1, 2'b00, 1'b0, 8'h00);
    issue(0); run(1, 34);
    // SUB-I rd=1 rs1=1 imm=111110, sign-extended
    setup(4'b1001, 3'd1, 3'd1, 6'b111110, 1'b0, 2'b00, 1'b1, 8'b1111_1110);
    issue(0); run(1, 34);
    // AND-I, positive immediate
    setup(4'b1010, 3'd7, 3'd2, 6'b000011, 1'b0, 2'b10, 1'b0, 8'b0000_0011);
    issue(0); run(1, 34);
    // XOR-I, negative immediate
    setup(4'b1100, 3'd6, 3'd4, 6'b100101, 1'b0, 2'b01, 1'b0, 8'b1110_0101);
    issue(0); run(1, 34);
    // OR R-type rs2=7
    setup(4'b0011, 3'd5, 3'd6, 6'b000111, 1'b1, 2'b11, 1'b0, 8'h00);
    issue(0); run(1, 34);
    // MOV rd=0: B forced to zero, writeback suppressed
    setup(4'b0101, 3'd0, 3'd5, 6'b101010, 1'b0, 2'b11, 1'b0, 8'h00);
    issue(0); run(1, 34);

    // Illegal opcode, abort coinciding with DONE
    setup(4'b0110, 3'd3, 3'd2, 6'b000001, 1'b1, 2'b00, 1'b0, 8'h00);
    issue(0);
    abort = 1'b1;
    ck("ill_done", 1, done, 1);
    ck("ill_err",  1, err, 1);
    ck("ill_outs", 1, outv & 12'hFFC, 0);
    ck("ill_rdy",  1, ready, 0);
    tick;
    abort = 1'b0;
    ck("ill_rdy2", 2, ready, 1);
    ck("ill_dn2",  2, done, 0);
    ck("ill_err2", 2, err, 0);

    // Abort at cycle 10 of ADD
    setup(4'b0000, 3'd2, 3'd3, 6'b000100, 1'b1, 2'b00, 1'b0, 8'h00);
    issue(0); run(1, 10);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    ck("abt_rdy", 11, ready, 1);
    ck("abt_dn",  11, done, 0);
    ck("abt_idx", 11, bit_idx, 0);
    ck("abt_rd",  11, reg_rd_en, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done) n++;
    end
    ck("abt_nodone", 12, n, 0);
    // Abort in IDLE does not block start
    abort = 1'b1;
    start = 1'b1;
    chk_cycle(0);
    tick;
    abort = 1'b0;
    start = 1'b0;
    run(1, 34);

    // Back-to-back: start held through DONE, accepted in the following IDLE cycle
    issue(1); run(1, 33);
    tick;
    chk_cycle(34);
    tick;
    start = 1'b0;
    run(1, 27);
    // Async reset mid-WB
    rstn = 1'b0;
    #1;
    ck("mrst_rdy",  0, ready, 1);
    ck("mrst_outs", 0, outv, 0);
    ck("mrst_addr", 0, reg_addr, 0);
    ck("mrst_alu",  0, alu_op, 0);
    ck("mrst_idx",  0, bit_idx, 0);
    tick;
    rstn = 1'b1;
    tick;
    setup(4'b0011, 3'd4, 3'd1, 6'b000010, 1'b1, 2'b11, 1'b0, 8'h00);
    issue(0); run(1, 34);

    // DATA_W=16 latency
    instr   = 16'b000100_011_010_0000;
    start16 = 1'b1;
    ck("w16_rdy0", 0, ready16, 1);
    tick;
    start16 = 1'b0;
    n = 1;
    while (!done16 && n < 200) begin
      tick;
      n++;
    end
    ck("w16_lat", n, n, 65);
    ck("w16_err", n, err16, 0);
    tick;
    ck("w16_rdy", n + 1, ready16, 1);
    ck("w16_dn",  n + 1, done16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
